// File: rtl/tlb_test_controller_if.sv
// Microcode TR-access port and paging-unit TLB port of the TR6/TR7 test controller.
// The master side is the environment (microcode and TLB). The slave side is the controller.
interface tlb_test_controller_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_index;
  logic [31:0] wr_data;
  logic [2:0]  rd_index;
  logic [31:0] rd_data;
  logic        busy;
  logic        tlb_timeout;
  logic        tlb_req;
  logic        tlb_op;
  logic [19:0] tlb_linear;
  logic [6:0]  tlb_attr;
  logic [19:0] tlb_phys;
  logic [1:0]  tlb_way;
  logic        tlb_ack;
  logic        tlb_hit;
  logic [1:0]  tlb_hit_way;
  logic [19:0] tlb_hit_phys;

  modport master (
    output wr_valid, wr_index, wr_data, rd_index,
    output tlb_ack, tlb_hit, tlb_hit_way, tlb_hit_phys,
    input  wr_ready, rd_data, busy, tlb_timeout,
    input  tlb_req, tlb_op, tlb_linear, tlb_attr, tlb_phys, tlb_way
  );

  modport slave (
    input  wr_valid, wr_index, wr_data, rd_index,
    input  tlb_ack, tlb_hit, tlb_hit_way, tlb_hit_phys,
    output wr_ready, rd_data, busy, tlb_timeout,
    output tlb_req, tlb_op, tlb_linear, tlb_attr, tlb_phys, tlb_way
  );
endinterface

// File: rtl/tlb_test_controller.sv
// TR6/TR7 TLB test sequencer: it holds the test registers and issues TLB writes or lookups on each TR6 write.
// A lookup result is folded back into TR7.
module tlb_test_controller #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic              clock,
  input  logic              reset,
  tlb_test_controller_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_LOOKUP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [26:0]      tr6_hi;      // TR6[31:5]: linear page and attribute bits
  logic             tr6_c;       // TR6[0]: 0 = write entry, 1 = lookup
  logic [19:0]      tr7_pa;
  logic             tr7_ht;
  logic [1:0]       tr7_rep;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;
  logic             accept;
  logic             expire;
  logic             unused_wr_bit;

  assign unused_wr_bit = bus.wr_data[1];

  assign accept = bus.wr_valid && (state == ST_IDLE);
  assign expire = (state != ST_IDLE) && !bus.tlb_ack && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.wr_valid && bus.wr_index == 3'd6)
          state_nxt = bus.wr_data[0] ? ST_LOOKUP : ST_WRITE;
      end
      ST_WRITE, ST_LOOKUP: begin
        if (bus.tlb_ack || expire)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tr6_hi    <= '0;
      tr6_c     <= 1'b0;
      tr7_pa    <= '0;
      tr7_ht    <= 1'b0;
      tr7_rep   <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && bus.wr_index == 3'd7) begin
        tr7_pa  <= bus.wr_data[31:12];
        tr7_ht  <= bus.wr_data[4];
        tr7_rep <= bus.wr_data[3:2];
      end
      if (accept && bus.wr_index == 3'd6) begin
        tr6_hi    <= bus.wr_data[31:5];
        tr6_c     <= bus.wr_data[0];
        timeout_q <= 1'b0;
        cnt       <= '0;
      end
      if (state != ST_IDLE) begin
        if (bus.tlb_ack) begin
          // A miss only clears HT; PA and REP keep whatever the test loaded.
          if (state == ST_LOOKUP) begin
            tr7_ht <= bus.tlb_hit;
            if (bus.tlb_hit) begin
              tr7_pa  <= bus.tlb_hit_phys;
              tr7_rep <= bus.tlb_hit_way;
            end
          end
        end else if (expire) begin
          timeout_q <= 1'b1;
          if (state == ST_LOOKUP)
            tr7_ht <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.wr_ready    = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.tlb_timeout = timeout_q;
  assign bus.tlb_req     = (state != ST_IDLE);
  assign bus.tlb_op      = tr6_c;
  assign bus.tlb_linear  = tr6_hi[26:7];
  assign bus.tlb_attr    = tr6_hi[6:0];
  assign bus.tlb_phys    = tr7_pa;
  assign bus.tlb_way     = tr7_rep;

  always_comb begin
    bus.rd_data = '0;
    case (bus.rd_index)
      3'd6:    bus.rd_data = {tr6_hi, 4'b0000, tr6_c};
      3'd7:    bus.rd_data = {tr7_pa, 7'b0000000, tr7_ht, tr7_rep, 2'b00};
      default: bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_tlb_test_controller.sv
// Bench for tlb_test_controller: directed scenarios plus randomized traffic.
// Results are compared against a register-level reference model.
module tb_tlb_test_controller;

  localparam int TIMEOUT = 15;
  localparam logic [31:0] TR6_MASK = 32'hFFFF_FFE1;
  localparam logic [31:0] TR7_MASK = 32'hFFFF_F01C;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  // reference model: architectural register values plus an outstanding-op tracker
  logic [31:0] m_tr6, m_tr7;
  logic        m_pending, m_timeout;
  int          m_age;

  tlb_test_controller_if bus ();

  tlb_test_controller #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_tr6 = '0; m_tr7 = '0; m_pending = 1'b0; m_timeout = 1'b0; m_age = 0;
  endtask

  task automatic m_step(input logic v, input logic [2:0] idx, input logic [31:0] d,
                        input logic a, input logic h, input logic [1:0] w, input logic [19:0] p);
    if (!m_pending) begin
      if (v && idx == 3'd7) m_tr7 = d & TR7_MASK;
      if (v && idx == 3'd6) begin
        m_tr6 = d & TR6_MASK; m_timeout = 1'b0; m_pending = 1'b1; m_age = 0;
      end
    end else if (a) begin
      if (m_tr6[0]) begin
        if (h) m_tr7 = {p, 7'd0, 1'b1, w, 2'b00};
        else   m_tr7 = m_tr7 & ~32'h10;
      end
      m_pending = 1'b0;
    end else begin
      m_age++;
      if (m_age == TIMEOUT) begin
        m_pending = 1'b0; m_timeout = 1'b1;
        if (m_tr6[0]) m_tr7 = m_tr7 & ~32'h10;
      end
    end
  endtask

  // Called at posedge+1: drive inputs, settle, compare, advance model, move to next posedge+1.
  task automatic cycle(input logic v, input logic [2:0] idx, input logic [31:0] d,
                       input logic a, input logic h, input logic [1:0] w, input logic [19:0] p,
                       input logic [2:0] ri);
    logic [31:0] exp_rd;
    bus.wr_valid = v; bus.wr_index = idx; bus.wr_data = d;
    bus.tlb_ack = a; bus.tlb_hit = h; bus.tlb_hit_way = w; bus.tlb_hit_phys = p;
    bus.rd_index = ri;
    #2;
    exp_rd = (ri == 3'd6) ? m_tr6 : (ri == 3'd7) ? m_tr7 : 32'd0;
    chk("rd_data", bus.rd_data, exp_rd);
    chk("wr_ready", 32'(bus.wr_ready), 32'(!m_pending));
    chk("busy", 32'(bus.busy), 32'(m_pending));
    chk("tlb_req", 32'(bus.tlb_req), 32'(m_pending));
    chk("tlb_timeout", 32'(bus.tlb_timeout), 32'(m_timeout));
    if (m_pending) begin
      chk("tlb_op", 32'(bus.tlb_op), 32'(m_tr6[0]));
      chk("tlb_linear", 32'(bus.tlb_linear), 32'(m_tr6[31:12]));
      chk("tlb_attr", 32'(bus.tlb_attr), 32'(m_tr6[11:5]));
      chk("tlb_phys", 32'(bus.tlb_phys), 32'(m_tr7[31:12]));
      chk("tlb_way", 32'(bus.tlb_way), 32'(m_tr7[3:2]));
    end
    m_step(v, idx, d, a, h, w, p);
    @(posedge clock); #1;
  endtask

  task automatic idle_cyc(input logic a);
    cycle(1'b0, 3'd0, 32'd0, a, 1'b0, 2'd0, 20'd0, 3'd7);
  endtask

  task automatic expect_rd(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    bus.rd_index = idx; #1;
    chk(tag, bus.rd_data, exp);
  endtask

  initial begin
    int req_cycles;
    int ack_pct;
    m_reset();
    bus.wr_valid = 0; bus.wr_index = 0; bus.wr_data = 0; bus.rd_index = 0;
    bus.tlb_ack = 0; bus.tlb_hit = 0; bus.tlb_hit_way = 0; bus.tlb_hit_phys = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    chk("rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_timeout", 32'(bus.tlb_timeout), 32'd0);
    expect_rd("rst_tr6", 3'd6, 32'd0);
    expect_rd("rst_tr7", 3'd7, 32'd0);
    @(posedge clock); #1;

    // 1: TLB write with explicit output values
    cycle(1, 3'd7, 32'h1234_500C, 0, 0, 0, 0, 3'd7);
    cycle(1, 3'd6, 32'hABCD_EFE0, 0, 0, 0, 0, 3'd6);
    chk("t1_req", 32'(bus.tlb_req), 32'd1);
    chk("t1_op", 32'(bus.tlb_op), 32'd0);
    chk("t1_linear", 32'(bus.tlb_linear), 32'h0ABCDE);
    chk("t1_attr", 32'(bus.tlb_attr), 32'h7F);
    chk("t1_phys", 32'(bus.tlb_phys), 32'h12345);
    chk("t1_way", 32'(bus.tlb_way), 32'd3);
    idle_cyc(0); idle_cyc(0); idle_cyc(1);
    chk("t1_ready", 32'(bus.wr_ready), 32'd1);
    expect_rd("t1_tr7", 3'd7, 32'h1234_500C);

    // 2: lookup hit
    cycle(1, 3'd6, 32'h0040_0001, 0, 0, 0, 0, 3'd6);
    cycle(0, 3'd0, 0, 1, 1, 2'd2, 20'h0F00D, 3'd7);
    chk("t2_ready", 32'(bus.wr_ready), 32'd1);
    expect_rd("t2_tr7", 3'd7, 32'h0F00_D018);

    // 3: lookup miss keeps PA/REP, clears HT
    cycle(1, 3'd7, 32'h1234_501C, 0, 0, 0, 0, 3'd7);
    cycle(1, 3'd6, 32'h0040_0001, 0, 0, 0, 0, 3'd6);
    cycle(0, 3'd0, 0, 1, 0, 2'd1, 20'hFFFFF, 3'd7);
    expect_rd("t3_tr7", 3'd7, 32'h1234_500C);

    // 4: lookup timeout
    cycle(1, 3'd7, 32'h1234_501C, 0, 0, 0, 0, 3'd7);
    cycle(1, 3'd6, 32'h0040_0001, 0, 0, 0, 0, 3'd6);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tlb_req) req_cycles++;
      idle_cyc(0);
    end
    chk("t4_req_cycles", 32'(req_cycles), 32'd15);
    chk("t4_timeout", 32'(bus.tlb_timeout), 32'd1);
    expect_rd("t4_tr7", 3'd7, 32'h1234_500C);
    cycle(1, 3'd6, 32'h0000_1000, 0, 0, 0, 0, 3'd6);
    chk("t4_clear", 32'(bus.tlb_timeout), 32'd0);
    idle_cyc(1);

    // 5: TR7 write held off while busy; ack on the last allowed cycle
    cycle(1, 3'd6, 32'h5555_5000, 0, 0, 0, 0, 3'd6);
    for (int i = 0; i < 14; i++) cycle(1, 3'd7, 32'hCAFE_F0FF, 0, 0, 0, 0, 3'd7);
    chk("t5_ready_busy", 32'(bus.wr_ready), 32'd0);
    expect_rd("t5_tr7_held", 3'd7, 32'h1234_500C);
    cycle(1, 3'd7, 32'hCAFE_F0FF, 1, 0, 0, 0, 3'd7);
    chk("t5_timeout", 32'(bus.tlb_timeout), 32'd0);
    cycle(1, 3'd7, 32'hCAFE_F0FF, 0, 0, 0, 0, 3'd7);
    expect_rd("t5_tr7", 3'd7, 32'hCAFE_F01C);

    // 6: async reset mid-lookup, then masking checks
    cycle(1, 3'd6, 32'h7777_7001, 0, 0, 0, 0, 3'd6);
    idle_cyc(0);
    #1 reset = 1'b0;
    #1 chk("t6_req_async", 32'(bus.tlb_req), 32'd0);
    m_reset();
    expect_rd("t6_tr6", 3'd6, 32'd0);
    expect_rd("t6_tr7", 3'd7, 32'd0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    cycle(1, 3'd6, 32'hFFFF_FFFF, 0, 0, 0, 0, 3'd6);
    idle_cyc(0); idle_cyc(0); idle_cyc(0);
    idle_cyc(1);
    expect_rd("t6_tr6_mask", 3'd6, 32'hFFFF_FFE1);
    cycle(1, 3'd3, 32'hFFFF_FFFF, 0, 0, 0, 0, 3'd3);
    expect_rd("t6_tr3", 3'd3, 32'd0);

    // randomized traffic with varying TLB responsiveness
    ack_pct = 30;
    for (int i = 0; i < 1200; i++) begin
      logic [2:0] idx;
      logic [31:0] d;
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 0;
          1: ack_pct = 10;
          2: ack_pct = 50;
          default: ack_pct = 100;
        endcase
      end
      idx = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(6, 7));
      d = $urandom;
      cycle(1'($urandom_range(0, 1)), idx, d,
            1'($urandom_range(0, 99) < ack_pct), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 20'($urandom), 3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
